// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: data-memory wait FSM with timeout,
// RAW hazard detection (load-use or full interlock), branch flush and a
// saturating stall-cycle counter. Control outputs are combinational so the
// pipeline reacts in the same cycle as the conditions that cause them.
module pipe_stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic        two_src,
  input  logic        forward_en,
  input  logic [4:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        freeze,
  output logic        hazard_stall,
  output logic        flush,
  output logic        mem_req,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  mem_state_t state;
  logic [7:0] wait_cnt;
  logic       access;
  logic       wait_expired;
  logic       raw_hazard;

  assign access = mem_r_en | mem_w_en;

  // The 256th consecutive WAIT cycle without mem_ready gives up on the access.
  assign wait_expired = (state == WAIT) && !mem_ready && (wait_cnt == 8'hFF);

  // True when a producer in flight writes a nonzero source register the ID
  // instruction still needs.
  function automatic logic src_hit(input logic [4:0] src);
    logic hit;
    hit = 1'b0;
    if (src != 5'd0) begin
      if (forward_en) begin
        // With forwarding only a load in EXE cannot supply its result in time.
        hit = exe_mem_r_en && (exe_dest == src);
      end else begin
        hit = (exe_wb_en && (exe_dest == src)) || (mem_wb_en && (mem_dest == src));
      end
    end
    return hit;
  endfunction

  // Hazard detection on the ID-stage operands.
  always_comb begin
    raw_hazard = src_hit(src1) || (two_src && src_hit(src2));
  end

  // Memory handshake outputs decoded from the current state; all forced low in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    mem_req = 1'b0;
    freeze  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mem_req = access;
          freeze  = access;
        end
        WAIT:    freeze = !mem_ready && !wait_expired;
        default: freeze = 1'b0;
      endcase
    end
  end

  // Freeze outranks both the branch flush and the hazard bubble; a taken branch
  // squashes the dependent instruction, so it needs no bubble.
  always_comb begin
    flush        = !rst && branch_taken && !freeze;
    hazard_stall = !rst && raw_hazard && !freeze && !branch_taken;
  end

  // Memory wait FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (access) begin
            state    <= WAIT;
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= DONE;
          end else if (wait_expired) begin
            state       <= IDLE;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        // The completed instruction is still in MEM this cycle; its request
        // lines are ignored so it is not issued twice.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which the pipeline front end was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if ((freeze || hazard_stall) && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
